capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
Sequences one MSO acquisition around the trigger hub. It arms and resets the hub, and drives the circular sample-buffer write side through pre-trigger fill, armed wait and post-trigger fill. It records the buffer address of the trigger sample and flags completion. It sits between the control/register block and the trigger_hub + capture RAM.

Parameters:
ADDR_WIDTH, 10, capture buffer address width; depth = 2**ADDR_WIDTH samples
AUTO_WIDTH, 16, width of auto-trigger timeout counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to begin an acquisition
abort  in  1  single-cycle request to cancel; highest priority
sample_en  in  1  sample strobe (decimated rate); all counting/writing qualified by it
pre_len  in  ADDR_WIDTH  pre-trigger sample count, latched on start
post_len  in  ADDR_WIDTH  post-trigger sample count, latched on start
auto_en  in  1  enable forced trigger on timeout, latched on start
auto_ticks  in  AUTO_WIDTH  sample strobes to wait in ARMED before forcing, latched on start
trig_in  in  1  trigger output of trigger_hub
hub_arm  out  1  level to trigger_hub arm
hub_reset  out  1  one-cycle pulse to trigger_hub reset
wr_en  out  1  capture RAM write enable
wr_addr  out  ADDR_WIDTH  capture RAM write address
trig_addr  out  ADDR_WIDTH  address of trigger sample, valid while done
busy  out  1  high in PRE/ARMED/POST
done  out  1  level, acquisition complete
forced  out  1  trigger was auto-forced, valid while done

Behaviour:
- Reset: state IDLE; all outputs 0; wr_addr=0, trig_addr=0; internal counters 0.
- States: IDLE, PRE, ARMED, POST, DONE (registered, encoding from package).
- wr_en = sample_en & (state in PRE/ARMED/POST), combinational. wr_addr increments after each write and wraps 2**ADDR_WIDTH-1 -> 0.
- IDLE/DONE + start: latch pre_len/post_len/auto_en/auto_ticks; wr_addr<=0; clear done/forced; hub_reset=1 for the next cycle.
  - Next state is PRE if pre_len!=0, else ARMED.
- PRE: count writes. On the write that makes count==pre_len -> ARMED.
- ARMED: hub_arm=1 (registered, high for every cycle in ARMED only).
  - Trigger accepted on sample_en & trig_in. That cycle's write is the trigger sample: trig_addr<=wr_addr.
  - Next state is POST if post_len!=0, else DONE.
  - If auto_en and auto_ticks strobes have elapsed without a trigger, treat the next strobe as the trigger with forced<=1.
  - auto_ticks=0 with auto_en: force on the first strobe.
- POST: after post_len further writes -> DONE.
- DONE: done=1, busy=0, hub_arm=0, wr_en=0. Outputs held until start (restart) or abort.
- abort in any state: next state IDLE, done/forced cleared, hub_reset pulsed. Abort wins over simultaneous start and trigger.
- start while busy: ignored.
- trig_in and timeout in the same strobe: genuine trigger, forced=0.
- trig_in without sample_en, or outside ARMED: ignored.
- pre_len+post_len+1 > depth is not checked; oldest samples are overwritten.
- Reset mid-acquisition: immediate return to reset values.

Decomposition:
- Package mso_capture_pkg: state encoding localparams (IDLE..DONE), default ADDR_WIDTH.
- One sub-module, capture_down_counter: loadable down-counter with enable and zero flag. Instantiated for pre, post and auto timeout.

Test Plan:
- ADDR_WIDTH=4, sample_en=1, pre=3, post=4, start at T -> writes addr 0,1,2 at T+1..T+3; hub_arm=1 from T+4.
  - Continuing the same run: trig_in at T+6 -> trig_addr=5; POST writes 6..9 at T+7..T+10; done=1, wr_en=0 at T+11; forced=0.
- pre=0, post=0, trig_in at T+2 -> ARMED at T+1, trig_addr=1, done at T+3.
- auto_en=1, auto_ticks=5, no trig_in -> forced=1, done asserted; trig_addr equals address of 6th ARMED strobe.
- sample_en every 4th cycle, pre=2, post=2 -> wr_en only on strobes; addresses contiguous; trig_in between strobes ignored.
- abort during POST (same cycle as start) -> IDLE next cycle, hub_reset pulse, busy=0, done=0; following start runs normally from wr_addr=0.
- pre=12, post=10 (exceeds depth 16) -> wr_addr wraps 15->0; trig_addr correct; rst asserted mid-POST -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mso_capture_pkg.sv
// Shared types for the MSO capture path: sequencer state encoding and default widths.
package mso_capture_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_AUTO_WIDTH = 16;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_PRE_ENC   = 3'd1;
    localparam logic [2:0] ST_ARMED_ENC = 3'd2;
    localparam logic [2:0] ST_POST_ENC  = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_PRE   = ST_PRE_ENC,
        ST_ARMED = ST_ARMED_ENC,
        ST_POST  = ST_POST_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/capture_down_counter.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
// Flags are decoded from the registered count so they describe the current cycle.
module capture_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == WIDTH'(1));

endmodule

// File: rtl/capture_sequencer.sv
// Runs one acquisition: pre-trigger fill, armed wait (with optional auto-force), post-trigger fill.
// Drives the circular capture-RAM write port and the trigger hub arm/reset controls.
module capture_sequencer
    import mso_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AUTO_WIDTH = DEFAULT_AUTO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  sample_en,
    input  logic [ADDR_WIDTH-1:0] pre_len,
    input  logic [ADDR_WIDTH-1:0] post_len,
    input  logic                  auto_en,
    input  logic [AUTO_WIDTH-1:0] auto_ticks,
    input  logic                  trig_in,
    output logic                  hub_arm,
    output logic                  hub_reset,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  forced
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic                  forced_q, forced_d;
    logic                  auto_en_q, auto_en_d;
    logic                  hub_reset_q, hub_reset_d;
    logic                  hub_arm_q;
    logic                  done_q;

    logic busy_c;
    logic load_c;
    logic pre_dec, post_dec, auto_dec;
    logic pre_one, post_one, post_zero, auto_zero;
    logic pre_zero_unused, auto_one_unused;

    assign busy_c = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);

    // All three counters are (re)loaded by an accepted start, so the lengths are latched there.
    capture_down_counter #(.WIDTH(ADDR_WIDTH)) u_pre_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .load_val_i (pre_len),
        .dec_i      (pre_dec),
        .zero_o     (pre_zero_unused),
        .one_o      (pre_one)
    );

    capture_down_counter #(.WIDTH(ADDR_WIDTH)) u_post_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .load_val_i (post_len),
        .dec_i      (post_dec),
        .zero_o     (post_zero),
        .one_o      (post_one)
    );

    capture_down_counter #(.WIDTH(AUTO_WIDTH)) u_auto_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_c),
        .load_val_i (auto_ticks),
        .dec_i      (auto_dec),
        .zero_o     (auto_zero),
        .one_o      (auto_one_unused)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = (sample_en && busy_c) ? wr_addr_q + ADDR_WIDTH'(1) : wr_addr_q;
        trig_addr_d = trig_addr_q;
        forced_d    = forced_q;
        auto_en_d   = auto_en_q;
        hub_reset_d = 1'b0;
        load_c      = 1'b0;
        pre_dec     = 1'b0;
        post_dec    = 1'b0;
        auto_dec    = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            forced_d    = 1'b0;
            hub_reset_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        load_c      = 1'b1;
                        auto_en_d   = auto_en;
                        wr_addr_d   = '0;
                        forced_d    = 1'b0;
                        hub_reset_d = 1'b1;
                        state_d     = (pre_len != '0) ? ST_PRE : ST_ARMED;
                    end
                end
                ST_PRE: begin
                    if (sample_en) begin
                        pre_dec = 1'b1;
                        if (pre_one) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    // A real trigger on the timeout strobe still counts as genuine.
                    if (sample_en) begin
                        if (trig_in || (auto_en_q && auto_zero)) begin
                            trig_addr_d = wr_addr_q;
                            forced_d    = ~trig_in;
                            state_d     = post_zero ? ST_DONE : ST_POST;
                        end else if (auto_en_q) begin
                            auto_dec = 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        post_dec = 1'b1;
                        if (post_one) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            forced_q    <= 1'b0;
            auto_en_q   <= 1'b0;
            hub_reset_q <= 1'b0;
            hub_arm_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            forced_q    <= forced_d;
            auto_en_q   <= auto_en_d;
            hub_reset_q <= hub_reset_d;
            hub_arm_q   <= (state_d == ST_ARMED);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign wr_en     = sample_en & busy_c;
    assign wr_addr   = wr_addr_q;
    assign trig_addr = trig_addr_q;
    assign busy      = busy_c;
    assign done      = done_q;
    assign forced    = forced_q;
    assign hub_arm   = hub_arm_q;
    assign hub_reset = hub_reset_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a 16-entry buffer and hand-computed expectations.
module tb_capture_sequencer;

    localparam int AW = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          sample_en = 1'b0;
    logic          auto_en = 1'b0;
    logic          trig_in = 1'b0;
    logic [AW-1:0] pre_len = '0;
    logic [AW-1:0] post_len = '0;
    logic [TW-1:0] auto_ticks = '0;
    logic          hub_arm, hub_reset, wr_en, busy, done, forced;
    logic [AW-1:0] wr_addr, trig_addr;

    int n_checks = 0;
    int n_errors = 0;
    int exp_addr;

    always #5 clk = ~clk;

    capture_sequencer #(.ADDR_WIDTH(AW), .AUTO_WIDTH(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sample_en  (sample_en),
        .pre_len    (pre_len),
        .post_len   (post_len),
        .auto_en    (auto_en),
        .auto_ticks (auto_ticks),
        .trig_in    (trig_in),
        .hub_arm    (hub_arm),
        .hub_reset  (hub_reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done),
        .forced     (forced)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Start is driven in the current cycle; returns one cycle later with start dropped.
    task automatic launch(input int pre, input int post, input logic aen, input int ticks);
        pre_len    = AW'(pre);
        post_len   = AW'(post);
        auto_en    = aen;
        auto_ticks = TW'(ticks);
        start      = 1'b1;
        next_cycle();
        start      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {hub_arm, hub_reset, wr_en, busy, done, forced}, 0);
        check({tag, "_wa"}, wr_addr, 0);
        check({tag, "_ta"}, trig_addr, 0);
    endtask

    initial begin
        next_cycle();
        next_cycle();
        settle();
        check_all_zero("reset");
        rst = 1'b0;
        next_cycle();

        // pre=3, post=4, continuous strobes, trigger on the third armed sample
        sample_en = 1'b1;
        launch(3, 4, 1'b0, 0);
        settle();
        check("t1_hub_reset", hub_reset, 1);
        check("t1_wr_en", wr_en, 1);
        check("t1_addr0", wr_addr, 0);
        check("t1_busy", busy, 1);
        next_cycle();
        start = 1'b1;
        settle();
        check("t1_addr1", wr_addr, 1);
        check("t1_hub_reset_end", hub_reset, 0);
        next_cycle();
        start = 1'b0;
        settle();
        check("t1_busy_start_ignored", wr_addr, 2);
        check("t1_arm_early", hub_arm, 0);
        next_cycle();
        settle();
        check("t1_arm", hub_arm, 1);
        check("t1_addr3", wr_addr, 3);
        next_cycle();
        next_cycle();
        trig_in = 1'b1;
        settle();
        check("t1_trig_cycle_addr", wr_addr, 5);
        next_cycle();
        trig_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t1_post_addr", wr_addr, 32'(6 + i));
            check("t1_post_arm", hub_arm, 0);
            next_cycle();
        end
        settle();
        check("t1_done", done, 1);
        check("t1_wr_en_done", wr_en, 0);
        check("t1_busy_done", busy, 0);
        check("t1_trig_addr", trig_addr, 5);
        check("t1_forced", forced, 0);

        // pre=0, post=0: armed immediately, done right after trigger
        launch(0, 0, 1'b0, 0);
        settle();
        check("t2_armed", hub_arm, 1);
        check("t2_done_cleared", done, 0);
        check("t2_addr0", wr_addr, 0);
        next_cycle();
        trig_in = 1'b1;
        next_cycle();
        trig_in = 1'b0;
        settle();
        check("t2_done", done, 1);
        check("t2_trig_addr", trig_addr, 1);
        check("t2_forced", forced, 0);

        // auto-trigger after 5 idle strobes: 6th armed strobe is forced
        launch(0, 0, 1'b1, 5);
        repeat (5) next_cycle();
        settle();
        check("t3_not_yet", done, 0);
        check("t3_addr_6th", wr_addr, 5);
        next_cycle();
        settle();
        check("t3_done", done, 1);
        check("t3_forced", forced, 1);
        check("t3_trig_addr", trig_addr, 5);

        // ticks=0 with a real trigger on the first strobe: genuine wins
        launch(0, 0, 1'b1, 0);
        trig_in = 1'b1;
        next_cycle();
        trig_in = 1'b0;
        settle();
        check("t3b_done", done, 1);
        check("t3b_forced", forced, 0);

        // ticks=0, no trigger: forced on first strobe
        launch(0, 0, 1'b1, 0);
        next_cycle();
        settle();
        check("t3c_done", done, 1);
        check("t3c_forced", forced, 1);
        auto_en = 1'b0;

        // decimated strobes every 4th cycle, pre=2 post=2, off-strobe trigger ignored
        sample_en = 1'b0;
        launch(2, 2, 1'b0, 0);
        exp_addr = 0;
        for (int k = 1; k <= 22; k++) begin
            sample_en = (k % 4 == 1);
            trig_in   = (k == 7) || (k == 13);
            settle();
            check("t4_wr_en", wr_en, 32'((k % 4 == 1) && (k <= 21)));
            if ((k % 4 == 1) && (k <= 21)) begin
                check("t4_addr", wr_addr, 32'(exp_addr));
                exp_addr++;
            end
            if (k == 12) begin
                check("t4_still_armed", hub_arm, 1);
            end
            next_cycle();
        end
        trig_in = 1'b0;
        settle();
        check("t4_done", done, 1);
        check("t4_trig_addr", trig_addr, 3);

        // abort together with start during POST
        sample_en = 1'b1;
        launch(0, 4, 1'b0, 0);
        trig_in = 1'b1;
        next_cycle();
        trig_in = 1'b0;
        next_cycle();
        abort = 1'b1;
        start = 1'b1;
        next_cycle();
        abort = 1'b0;
        start = 1'b0;
        settle();
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_hub_reset", hub_reset, 1);
        check("t5_wr_en", wr_en, 0);
        check("t5_arm", hub_arm, 0);
        next_cycle();
        settle();
        check("t5_hub_reset_end", hub_reset, 0);
        launch(1, 1, 1'b0, 0);
        settle();
        check("t5_restart_addr", wr_addr, 0);
        next_cycle();
        trig_in = 1'b1;
        settle();
        check("t5_arm_again", hub_arm, 1);
        next_cycle();
        trig_in = 1'b0;
        settle();
        check("t5_post_addr", wr_addr, 2);
        next_cycle();
        settle();
        check("t5_done_again", done, 1);
        check("t5_trig_addr", trig_addr, 1);

        // pre=12, post=10 on a 16-deep buffer: address wraps
        launch(12, 10, 1'b0, 0);
        repeat (12) next_cycle();
        settle();
        check("t6_arm", hub_arm, 1);
        next_cycle();
        trig_in = 1'b1;
        settle();
        check("t6_trig_cycle_addr", wr_addr, 13);
        next_cycle();
        trig_in = 1'b0;
        next_cycle();
        settle();
        check("t6_addr15", wr_addr, 15);
        next_cycle();
        settle();
        check("t6_wrap", wr_addr, 0);
        repeat (8) next_cycle();
        settle();
        check("t6_done", done, 1);
        check("t6_trig_addr", trig_addr, 13);
        check("t6_wr_en_done", wr_en, 0);

        // same run, reset asserted between clock edges mid-POST
        launch(12, 10, 1'b0, 0);
        trig_in = 1'b0;
        repeat (13) next_cycle();
        trig_in = 1'b1;
        next_cycle();
        trig_in = 1'b0;
        repeat (4) next_cycle();
        settle();
        check("t6b_mid_post", busy, 1);
        check("t6b_mid_addr", wr_addr, 2);
        rst = 1'b1;
        #1;
        check_all_zero("t6b_async_rst");
        next_cycle();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
